// File: rtl/z80_bus_pkg.sv
// Shared constants for the tv80 bus fabric: open-bus value, UART window
// geometry and the wait-state FSM encoding.
package z80_bus_pkg;

  // Value returned on a read that selects nothing (also interrupt acknowledge).
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // The UART occupies a 4-byte I/O window; the low address bits pick its register.
  localparam int UART_WIN = 4;
  localparam int UART_AW  = $clog2(UART_WIN);

  // Wait-state generator states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/z80_bus_fabric_if.sv
// CPU-side bus of the tv80 core as seen by the fabric.
interface z80_bus_fabric_if;
  logic [15:0] addr;
  logic [7:0]  cpu_do;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic [7:0]  cpu_di;
  logic        wait_n;

  // The CPU drives the address/control/write data and consumes read data and wait.
  modport master (
    output addr, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n,
    input  cpu_di, wait_n
  );

  // The fabric decodes the bus and answers with read data and wait.
  modport slave (
    input  addr, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n,
    output cpu_di, wait_n
  );
endinterface

// File: rtl/z80_wait_gen.sv
// Memory wait-state generator: stretches each decoded memory access by
// MEM_WAIT cycles, triggered on the falling edge of mreq_n.
module z80_wait_gen #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_mreq_n,
  input  logic i_mem_sel,
  output logic o_wait_n
);
  import z80_bus_pkg::*;

  localparam bit         WAIT_EN = (MEM_WAIT > 0);
  localparam logic [2:0] LOAD    = 3'(WAIT_EN ? MEM_WAIT - 1 : 0);

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic       r_mreq_q;
  logic       r_wait_n;
  logic       w_start;

  // A new access begins on the mreq_n fall inside the decoded memory range.
  assign w_start  = WAIT_EN && r_mreq_q && !i_mreq_n && i_mem_sel;
  assign o_wait_n = r_wait_n;

  // FSM, counter and mreq_n history; wait_n is registered here.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_mreq_q <= 1'b1;
      r_wait_n <= 1'b1;
    end else begin
      r_mreq_q <= i_mreq_n;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_WAIT;
            r_cnt    <= LOAD;
            r_wait_n <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_mreq_n) begin
            // CPU abandoned the access: release wait and re-arm.
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_wait_n <= 1'b1;
          end else if (r_cnt == 3'd0) begin
            r_state  <= ST_HOLD;
            r_wait_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_HOLD: begin
          // Stay here until the access ends so one access gives one stretch.
          if (i_mreq_n) r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_wait_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/z80_bus_fabric.sv
// Bus fabric between tv80 and its peripherals: memory/I-O decode, registered
// read mux, N write-strobed output ports and memory wait-state insertion.
module z80_bus_fabric #(
  parameter int         MEM_AW    = 10,
  parameter int         MEM_WAIT  = 0,
  parameter int         N_PORTS   = 4,
  parameter logic [7:0] PORT_BASE = 8'hB8,
  parameter logic [7:0] UART_BASE = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  z80_bus_fabric_if.slave        bus,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic                   mem_we,
  input  logic [7:0]             mem_dout,
  output logic                   uart_en,
  output logic                   uart_wr,
  input  logic [7:0]             uart_dout,
  output logic [8*N_PORTS-1:0]   port_q,
  output logic [N_PORTS-1:0]     port_stb
);
  import z80_bus_pkg::*;

  logic               w_mem_sel;
  logic               w_io_cyc;
  logic               w_uart_sel;
  logic [N_PORTS-1:0] w_port_sel;
  logic [7:0]         w_port_rd;
  logic               w_wr_ev;
  logic               w_wait_n;
  logic               w_unused;
  logic               r_wr_q;
  logic [7:0]         r_cpu_di;

  // Read data is chosen purely by address decode, so rd_n carries no information here.
  assign w_unused = bus.rd_n;

  // Memory decode; a full 16-bit memory has no upper address bits to compare.
  generate
    if (MEM_AW >= 16) begin : g_mem_full
      assign w_mem_sel = !bus.mreq_n;
    end else begin : g_mem_part
      assign w_mem_sel = !bus.mreq_n && (bus.addr[15:MEM_AW] == '0);
    end
  endgenerate

  // Interrupt acknowledge (iorq_n and m1_n both low) is not an I/O cycle.
  assign w_io_cyc   = !bus.iorq_n && bus.m1_n;
  assign w_uart_sel = w_io_cyc && (bus.addr[7:UART_AW] == UART_BASE[7:UART_AW]);

  assign mem_addr = bus.addr[MEM_AW-1:0];
  assign mem_we   = w_mem_sel && !bus.wr_n;
  assign uart_en  = w_uart_sel;
  assign uart_wr  = w_uart_sel && !bus.wr_n;

  // A port write fires once, on the first cycle wr_n is seen low.
  assign w_wr_ev = r_wr_q && !bus.wr_n;

  // wr_n history for write-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wr_q <= 1'b1;
    else          r_wr_q <= bus.wr_n;
  end

  // Output port bank: one register and strobe per port address.
  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      localparam logic [7:0] P_ADDR = PORT_BASE + 8'(i);
      logic [7:0] r_q;
      logic       r_stb;

      assign w_port_sel[i]    = w_io_cyc && (bus.addr[7:0] == P_ADDR);
      assign port_q[8*i +: 8] = r_q;
      assign port_stb[i]      = r_stb;

      // Capture write data and pulse the strobe on a write event to this port.
      // NOTE: these are individual flops rather than a memory array, so they take a reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_q   <= 8'h00;
          r_stb <= 1'b0;
        end else begin
          r_stb <= w_wr_ev && w_port_sel[i];
          if (w_wr_ev && w_port_sel[i]) r_q <= bus.cpu_do;
        end
      end
    end
  endgenerate

  // Read-back value of whichever port is addressed (port addresses are distinct).
  // NOTE: default assignment first keeps this block purely combinational.
  always_comb begin
    w_port_rd = 8'h00;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_port_sel[i]) w_port_rd = w_port_rd | port_q[8*i +: 8];
    end
  end

  // Registered read mux; memory has priority if the bus is driven illegally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_cpu_di <= OPEN_BUS;
    else if (w_mem_sel)   r_cpu_di <= mem_dout;
    else if (w_uart_sel)  r_cpu_di <= uart_dout;
    else if (|w_port_sel) r_cpu_di <= w_port_rd;
    else                  r_cpu_di <= OPEN_BUS;
  end

  assign bus.cpu_di = r_cpu_di;
  assign bus.wait_n = w_wait_n;

  z80_wait_gen #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_mreq_n  (bus.mreq_n),
    .i_mem_sel (w_mem_sel),
    .o_wait_n  (w_wait_n)
  );

endmodule

// File: tb/tb_z80_bus_fabric.sv
// Self-checking bench for z80_bus_fabric: expected values are queued when a
// bus cycle is driven and popped as the matching DUT output is sampled.
module tb_z80_bus_fabric;

  localparam int         MEM_AW    = 10;
  localparam int         MEM_WAIT  = 2;
  localparam int         N_PORTS   = 4;
  localparam logic [7:0] PORT_BASE = 8'hB8;
  localparam logic [7:0] UART_BASE = 8'h00;

  logic                 clk;
  logic                 reset_n;
  logic [MEM_AW-1:0]    mem_addr;
  logic                 mem_we;
  logic [7:0]           mem_dout;
  logic                 uart_en;
  logic                 uart_wr;
  logic [7:0]           uart_dout;
  logic [8*N_PORTS-1:0] port_q;
  logic [N_PORTS-1:0]   port_stb;

  z80_bus_fabric_if bus ();

  z80_bus_fabric #(
    .MEM_AW    (MEM_AW),
    .MEM_WAIT  (MEM_WAIT),
    .N_PORTS   (N_PORTS),
    .PORT_BASE (PORT_BASE),
    .UART_BASE (UART_BASE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .uart_en   (uart_en),
    .uart_wr   (uart_wr),
    .uart_dout (uart_dout),
    .port_q    (port_q),
    .port_stb  (port_stb)
  );

  // Peripheral stubs with recognisable read data.
  assign mem_dout  = mem_addr[7:0] ^ 8'h3C;
  assign uart_dout = 8'h90 | {6'b0, bus.addr[1:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  logic [31:0] port_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic mreq, input logic iorq,
                       input logic rd, input logic wr, input logic m1, input logic [7:0] d);
    bus.addr   = a;
    bus.mreq_n = mreq;
    bus.iorq_n = iorq;
    bus.rd_n   = rd;
    bus.wr_n   = wr;
    bus.m1_n   = m1;
    bus.cpu_do = d;
  endtask

  // Inputs change at the falling edge; registered outputs are sampled at the next one.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    tick();
  endtask

  // One I/O write to a port address; expectations come from the port model.
  task automatic port_write(input logic [7:0] a, input logic [7:0] d);
    logic [3:0] stb_exp;
    int idx;
    stb_exp = 4'b0000;
    idx = int'(a) - int'(PORT_BASE);
    if (idx >= 0 && idx < N_PORTS) begin
      stb_exp[idx] = 1'b1;
      port_model[8*idx +: 8] = d;
    end
    drive({8'h00, a}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, d);
    sb_push($sformatf("pw_stb_%h", a), 32'(stb_exp));
    sb_push($sformatf("pw_q_%h", a), port_model);
    tick();
    sb_pop(32'(port_stb));
    sb_pop(port_q);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    port_model = 32'h0;
    reset_n = 1'b0;
    drive(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    repeat (2) tick();

    // Reset values.
    sb_push("rst_cpu_di", 32'hFF);
    sb_push("rst_wait_n", 32'd1);
    sb_push("rst_port_q", 32'h0);
    sb_push("rst_port_stb", 32'h0);
    sb_pop(32'(bus.cpu_di));
    sb_pop(32'(bus.wait_n));
    sb_pop(port_q);
    sb_pop(32'(port_stb));
    reset_n = 1'b1;
    tick();

    // I/O write 5A to BA with wr_n held low for three cycles: one update, one strobe.
    port_model[23:16] = 8'h5A;
    drive(16'h00BA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    sb_push("pw_stb_first", 32'h4);
    sb_push("pw_q_first", port_model);
    tick();
    sb_pop(32'(port_stb));
    sb_pop(port_q);
    sb_push("pw_stb_held1", 32'h0);
    tick();
    sb_pop(32'(port_stb));
    sb_push("pw_stb_held2", 32'h0);
    drive(16'h00BA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    tick();
    sb_pop(32'(port_stb));
    sb_push("pw_q_held", port_model);
    sb_pop(port_q);
    idle();

    // I/O read of BA returns the written value one cycle later.
    drive(16'h00BA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    sb_push("pr_cpu_di", 32'h5A);
    tick();
    sb_pop(32'(bus.cpu_di));
    idle();

    // Lowest and highest port addresses, and the first address past the bank.
    port_write(8'hB8, 8'h11);
    port_write(8'hBB, 8'hC3);
    port_write(8'hBC, 8'h77);

    // Memory read at 0010 with two wait states.
    drive(16'h0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    #1;
    sb_push("mem_addr", 32'h010);
    sb_pop(32'(mem_addr));
    sb_push("ws_before", 32'd1);
    sb_pop(32'(bus.wait_n));
    sb_push("ws_cycle1", 32'd0);
    sb_push("mem_cpu_di", 32'(8'h10 ^ 8'h3C));
    tick();
    sb_pop(32'(bus.wait_n));
    sb_pop(32'(bus.cpu_di));
    sb_push("ws_cycle2", 32'd0);
    tick();
    sb_pop(32'(bus.wait_n));
    sb_push("ws_release", 32'd1);
    tick();
    sb_pop(32'(bus.wait_n));
    sb_push("ws_hold", 32'd1);
    tick();
    sb_pop(32'(bus.wait_n));
    idle();

    // Memory read outside the decoded range: open bus, no wait states.
    drive(16'h0400, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    sb_push("oor_cpu_di", 32'hFF);
    sb_push("oor_wait1", 32'd1);
    tick();
    sb_pop(32'(bus.cpu_di));
    sb_pop(32'(bus.wait_n));
    sb_push("oor_wait2", 32'd1);
    tick();
    sb_pop(32'(bus.wait_n));
    drive(16'h0400, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAB);
    #1;
    sb_push("oor_mem_we", 32'd0);
    sb_pop(32'(mem_we));
    drive(16'h0020, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAB);
    #1;
    sb_push("in_mem_we", 32'd1);
    sb_pop(32'(mem_we));
    tick();
    idle();

    // UART window write, read, then interrupt acknowledge at 00.
    drive(16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
    #1;
    sb_push("uart_en_wr", 32'd1);
    sb_push("uart_wr", 32'd1);
    sb_pop(32'(uart_en));
    sb_pop(32'(uart_wr));
    tick();
    drive(16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    #1;
    sb_push("uart_rd_wr", 32'd0);
    sb_pop(32'(uart_wr));
    sb_push("uart_cpu_di", 32'h92);
    tick();
    sb_pop(32'(bus.cpu_di));
    drive(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    sb_push("intack_uart_en", 32'd0);
    sb_pop(32'(uart_en));
    sb_push("intack_cpu_di", 32'hFF);
    tick();
    sb_pop(32'(bus.cpu_di));
    idle();

    // Reset asserted mid-wait releases everything immediately.
    drive(16'h0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    sb_push("mid_wait_low", 32'd0);
    sb_push("mid_cpu_di", 32'(8'h10 ^ 8'h3C));
    tick();
    sb_pop(32'(bus.wait_n));
    sb_pop(32'(bus.cpu_di));
    reset_n = 1'b0;
    #1;
    sb_push("arst_wait_n", 32'd1);
    sb_push("arst_cpu_di", 32'hFF);
    sb_push("arst_port_q", 32'h0);
    sb_push("arst_port_stb", 32'h0);
    sb_pop(32'(bus.wait_n));
    sb_pop(32'(bus.cpu_di));
    sb_pop(port_q);
    sb_pop(32'(port_stb));
    idle();
    reset_n = 1'b1;
    idle();

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
